wordram_sched: RTL and testbench
================================

// Module: wordram_sched
// PURPOSE
//  Owns the single-port word RAM. Treats it as a circular character buffer.
//  Arbitrates RAM access between two requesters:
//   - capture side: serial-receive bytes in.
//   - playback side: stored bytes out to the cereal transmitter.
//  Sequences playback: one character per transmitter handshake, from play request until the buffer is empty.
// PARAMETERS
//  ADDR_W   8    RAM address width; DEPTH = 2**ADDR_W words
// PORTS
//  sysclk     in   1         system clock; all state on rising edge
//  reset      in   1         asynchronous, active-high reset
//  wr_req     in   1         1-cycle pulse: wr_data is valid, store it
//  wr_data    in   8         captured character
//  wr_ack     out  1         1-cycle pulse in the cycle the RAM write is issued
//  play       in   1         1-cycle pulse: start draining the buffer
//  tx_start   out  1         1-cycle pulse: tx_data is valid, transmitter starts
//  tx_data    out  8         character to transmit; held until the next tx_start
//  tx_done    in   1         1-cycle pulse from transmitter: character finished
//  ram_addr   out  ADDR_W    RAM address
//  ram_we     out  1         RAM write enable
//  ram_din    out  16        RAM write word = {1'b1, 7'b0, wr_data}
//  ram_dout   in   16        RAM read word; valid 1 cycle after the address is issued
//  count      out  ADDR_W+1  number of stored characters, 0..DEPTH
//  playing    out  1         high while playback is active
//  err        out  1         sticky error flag; cleared only by reset
// BEHAVIOUR
//  Reset values:
//   - all outputs are 0.
//   - wr_ptr = rd_ptr = 0; FSM in IDLE; pending-write latch empty.
//   - RAM contents are not cleared.
//  Reset mid-operation:
//   - aborts everything immediately, including any tx in flight.
//   - tx_start is not re-issued after reset.
//  Write latch:
//   - wr_req loads a 1-entry latch.
//   - If wr_req arrives while the latch is already full: the new byte is dropped and err is set.
//  FSM states: IDLE, WR, RD_ISSUE, RD_CAP, TX_GO, TX_WAIT.
//  IDLE:
//   - Latch full and (count<DEPTH or overwrite enabled) -> WR.
//   - Else playing and count>0 -> RD_ISSUE.
//   - Else stay in IDLE.
//  Arbitration when both a write and a read are eligible in IDLE:
//   - A write wins, unless the previous grant was also a write. Then the read wins.
//   - The result is strict alternation, and neither side starves.
//  WR (1 cycle):
//   - ram_we=1, ram_addr=wr_ptr, wr_ack=1.
//   - wr_ptr+1 (mod DEPTH), count+1; latch cleared -> IDLE.
//  RD_ISSUE (1 cycle): ram_addr=rd_ptr, ram_we=0 -> RD_CAP.
//  RD_CAP: sample ram_dout.
//   - If bit15==0 (corrupt word): set err, clear playing -> IDLE.
//   - Else: tx_data<=ram_dout[7:0], rd_ptr+1, count-1 -> TX_GO.
//  TX_GO (1 cycle): tx_start=1 -> TX_WAIT.
//  TX_WAIT: wait for tx_done.
//   - Then, if count==0: clear playing.
//   - Go to IDLE in either case.
//   - Captures are still serviced: from TX_WAIT, a pending write may take a WR cycle, then return to TX_WAIT.
//  Latency:
//   - play to first tx_start = 4 cycles when idle (IDLE, RD_ISSUE, RD_CAP, TX_GO).
//   - wr_req to wr_ack = 2 cycles when uncontended.
//  play:
//   - Sets playing when count>0. Ignored when count==0.
//   - A play pulse while already playing is ignored.
//  Simultaneous WR and RD_CAP in one cycle: impossible, because the FSM grants one access per cycle.
//  count arithmetic:
//   - Saturates at DEPTH and at 0.
//   - count==DEPTH means full (wr_ptr==rd_ptr with count!=0).
// CONFIGURATION
//  WORDRAM_OVERWRITE_EN defined:
//   - A write when full still executes.
//   - It overwrites the oldest word: rd_ptr+1, count stays at DEPTH, err is not set.
//  WORDRAM_OVERWRITE_EN undefined:
//   - A write when full is dropped: latch cleared, no wr_ack, err set.
// TESTING
//  1. Write 'H','I' (0x48, 0x49), spaced 5 cycles apart:
//     - wr_ack 2 cycles after each wr_req.
//     - RAM[0]=0x8048, RAM[1]=0x8049; count=2.
//  2. play with count=2:
//     - tx_start 4 cycles later with tx_data=0x48.
//     - After tx_done: tx_start with 0x49.
//     - After the 2nd tx_done: playing=0, count=0.
//  3. Write during TX_WAIT, and a write plus a read eligible together:
//     - The write is acked while the tx is waiting.
//     - Grants alternate W, R, W: no two consecutive writes while a read is eligible.
//  4. Fill 256 then write 0x5A:
//     - _EN undefined: no ack, err=1, count=256.
//     - _EN defined: RAM[0]=0x805A, rd_ptr=1, err=0.
//  5. Two wr_req pulses 1 cycle apart -> the first is stored, the second is dropped, err=1.
//  6. Assert reset during TX_WAIT, and separately preload RAM[0]=0x0041 then play:
//     - Reset case: outputs 0, count=0, no further tx_start.
//     - Preload case: err=1, playing=0, no tx_start.

Source files
------------

// File: rtl/wordram_sched.sv
// wordram_sched
//   Owns a single-port word RAM and uses it as a circular character buffer.
//   Arbitrates RAM access between a capture side (bytes written through a
//   one-entry latch) and a playback side (bytes read back and handed to a
//   serial transmitter one handshake at a time).
//
// Ports
//   sysclk    : system clock, all state on rising edge
//   reset     : asynchronous, active-high reset
//   wr_req    : 1-cycle pulse, wr_data valid
//   wr_data   : captured character
//   wr_ack    : pulse in the cycle the RAM write is issued
//   play      : pulse, start draining the buffer
//   tx_start  : pulse, tx_data valid for the transmitter
//   tx_data   : character to transmit, held until the next tx_start
//   tx_done   : pulse from transmitter, character finished
//   ram_addr  : RAM address
//   ram_we    : RAM write enable
//   ram_din   : RAM write word {1'b1, 7'b0, data}
//   ram_dout  : RAM read word, valid one cycle after the address
//   count     : stored characters, 0..DEPTH
//   playing   : playback active
//   err       : sticky error (dropped byte, write when full, corrupt word)
//
// Build option
//   WORDRAM_OVERWRITE_EN : when defined, a write into a full buffer replaces
//                          the oldest word instead of being dropped.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | arbitrate between pending write and playback read
// WR       | RAM write of the latched byte
// RD_ISSUE | read address driven
// RD_CAP   | read word captured and validated
// TX_GO    | tx_start pulse
// TX_WAIT  | waiting for tx_done; pending writes may still be serviced

module wordram_sched #(
  parameter int ADDR_W = 8
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [7:0]        wr_data,
  output logic              wr_ack,
  input  logic              play,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout,
  output logic [ADDR_W:0]   count,
  output logic              playing,
  output logic              err
);

`ifdef WORDRAM_OVERWRITE_EN
  localparam bit OVW = 1'b1;
`else
  localparam bit OVW = 1'b0;
`endif

  localparam logic [ADDR_W:0]   DEPTH   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_CAP, TX_GO, TX_WAIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q;
  logic              lat_full_q;
  logic [7:0]        lat_data_q;
  logic              last_wr_q;   // previous grant was a write
  logic              ret_tx_q;    // WR was entered from TX_WAIT
  logic              done_q;      // tx_done seen since the last tx_start
  logic              playing_q, err_q;
  logic [7:0]        tx_data_q;

  logic full, wr_elig, rd_elig, drop, tx_fin;

  assign full    = (count_q == DEPTH);
  assign wr_elig = lat_full_q && (!full || OVW);
  assign rd_elig = playing_q && (count_q != '0);
  // A latched byte that can never be written is discarded at a decision point.
  assign drop    = lat_full_q && full && !OVW &&
                   (state_q == IDLE || state_q == TX_WAIT);
  // tx_done may land while a write borrowed the RAM from TX_WAIT.
  assign tx_fin  = tx_done || done_q;

  always_comb begin
    state_d  = state_q;
    wr_ack   = 1'b0;
    ram_we   = 1'b0;
    tx_start = 1'b0;
    ram_addr = rd_ptr_q;
    ram_din  = '0;
    case (state_q)
      IDLE: begin
        if (wr_elig && (!rd_elig || !last_wr_q)) state_d = WR;
        else if (rd_elig)                          state_d = RD_ISSUE;
      end
      WR: begin
        ram_we   = 1'b1;
        wr_ack   = 1'b1;
        ram_addr = wr_ptr_q;
        ram_din  = {1'b1, 7'b0, lat_data_q};
        state_d  = ret_tx_q ? TX_WAIT : IDLE;
      end
      RD_ISSUE: state_d = RD_CAP;
      RD_CAP:   state_d = ram_dout[15] ? TX_GO : IDLE;
      TX_GO: begin
        tx_start = 1'b1;
        state_d  = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_fin)       state_d = IDLE;
        else if (wr_elig) state_d = WR;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lat_full_q <= 1'b0;
      lat_data_q <= '0;
      last_wr_q  <= 1'b0;
      ret_tx_q   <= 1'b0;
      done_q     <= 1'b0;
      playing_q  <= 1'b0;
      err_q      <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q  <= state_d;
      ret_tx_q <= (state_q == TX_WAIT);
      done_q   <= (state_q == TX_GO) ? 1'b0 : (done_q | tx_done);

      if (state_q == WR)            last_wr_q <= 1'b1;
      else if (state_q == RD_ISSUE) last_wr_q <= 1'b0;

      if (state_q == WR || drop) lat_full_q <= 1'b0;
      if (drop) err_q <= 1'b1;
      if (wr_req) begin
        if (lat_full_q) begin
          err_q <= 1'b1;
        end else begin
          lat_full_q <= 1'b1;
          lat_data_q <= wr_data;
        end
      end

      if (play && !playing_q && count_q != '0) playing_q <= 1'b1;

      case (state_q)
        WR: begin
          wr_ptr_q <= wr_ptr_q + PTR_ONE;
          // Only reachable when full if overwrite is built in: drop the oldest.
          if (full) rd_ptr_q <= rd_ptr_q + PTR_ONE;
          else      count_q  <= count_q + CNT_ONE;
        end
        RD_CAP: begin
          if (ram_dout[15]) begin
            tx_data_q <= ram_dout[7:0];
            rd_ptr_q  <= rd_ptr_q + PTR_ONE;
            if (count_q != '0) count_q <= count_q - CNT_ONE;
          end else begin
            err_q     <= 1'b1;
            playing_q <= 1'b0;
          end
        end
        TX_WAIT: begin
          if (tx_fin && count_q == '0) playing_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign tx_data = tx_data_q;
  assign count   = count_q;
  assign playing = playing_q;
  assign err     = err_q;

endmodule

// File: tb/tb_wordram_sched.sv
// Testbench for wordram_sched: cycle table for capture and playback, then
// hand sequences for arbitration, overflow, back-to-back writes, reset
// during transmit and corrupt-word detection.
module tb_wordram_sched;

  logic        sysclk, reset;
  logic        wr_req, play, wr_ack, tx_start, tx_done, ram_we, playing, err;
  logic [7:0]  wr_data, tx_data, ram_addr;
  logic [15:0] ram_din, ram_dout;
  logic [8:0]  count;
  logic        man_done, auto_done, auto_tx;

  logic [15:0] mem [256];
  logic        pre_en;
  logic [7:0]  pre_addr;
  logic [15:0] pre_val;

  int n_cmp, n_bad, n_ack, n_tx, ev_n;
  logic [7:0] ev_log [64];

  assign tx_done = man_done | auto_done;

  wordram_sched #(.ADDR_W(8)) dut (
    .sysclk(sysclk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ack(wr_ack), .play(play), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_din(ram_din), .ram_dout(ram_dout), .count(count),
    .playing(playing), .err(err)
  );

  initial begin
    sysclk = 1'b0;
    forever #5 sysclk = ~sysclk;
  end

  // synchronous single-port RAM, read data one cycle after the address
  always @(posedge sysclk) begin
    if (pre_en)      mem[pre_addr] <= pre_val;
    else if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout <= mem[ram_addr];
  end

  always @(negedge sysclk) begin
    if (!reset) begin
      if (wr_ack) begin
        n_ack++;
        if (ev_n < 64) ev_log[ev_n] = "W";
        ev_n++;
      end
      if (tx_start) begin
        n_tx++;
        if (ev_n < 64) ev_log[ev_n] = "R";
        ev_n++;
      end
    end
  end

  // transmitter model: tx_done three cycles after tx_start when enabled
  initial begin
    auto_done = 1'b0;
    forever begin
      @(negedge sysclk);
      if (auto_tx && tx_start) begin
        repeat (3) @(negedge sysclk);
        auto_done = 1'b1;
        @(negedge sysclk);
        auto_done = 1'b0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       wr_req;
    logic [7:0] wr_data;
    logic       play;
    logic       tx_done;
    logic       wr_ack;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [8:0] count;
    logic       playing;
    logic       err;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic w, input logic [7:0] d, input logic p, input logic dn,
                     input logic ea, input logic es, input logic [7:0] ed,
                     input logic [8:0] ec, input logic ep, input logic ee);
    vec_t v;
    v.wr_req = w; v.wr_data = d; v.play = p; v.tx_done = dn;
    v.wr_ack = ea; v.tx_start = es; v.tx_data = ed; v.count = ec;
    v.playing = ep; v.err = ee;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    wr_req = 1'b1; wr_data = d;
    @(negedge sysclk);
    wr_req = 1'b0;
  endtask

  task automatic pulse_play();
    play = 1'b1;
    @(negedge sysclk);
    play = 1'b0;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return tx_start;
      1:       return wr_ack;
      default: return !playing;
    endcase
  endfunction

  task automatic wait_for(input int which, input int limit, input string name);
    int k;
    k = 0;
    while (!cond(which) && k < limit) begin
      @(negedge sysclk);
      k++;
    end
    chk(name, 32'(cond(which)), 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wr_ack"},   32'(wr_ack),   32'd0);
    chk({tag, "_tx_start"}, 32'(tx_start), 32'd0);
    chk({tag, "_tx_data"},  32'(tx_data),  32'd0);
    chk({tag, "_count"},    32'(count),    32'd0);
    chk({tag, "_playing"},  32'(playing),  32'd0);
    chk({tag, "_err"},      32'(err),      32'd0);
    chk({tag, "_ram_we"},   32'(ram_we),   32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_din"},  32'(ram_din),  32'd0);
  endtask

  initial begin
    int base, a0, t0;
    logic [7:0] exp_ev [6];
    n_cmp = 0; n_bad = 0; n_ack = 0; n_tx = 0; ev_n = 0;
    reset = 1'b1; wr_req = 1'b0; wr_data = '0; play = 1'b0;
    man_done = 1'b0; auto_tx = 1'b0;
    pre_en = 1'b0; pre_addr = '0; pre_val = '0;
    cyc(2);
    reset = 1'b0;
    @(negedge sysclk);
    chk_idle_outputs("reset");

    // capture 'H','I' five cycles apart, then play both out
    //  wr     d     play done | ack   start txd    cnt   play  err
    add(1'b1, 8'h48, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 9'd0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd1, 1'b0, 1'b0);
    add(1'b1, 8'h49, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 9'd1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd2, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd2, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd2, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd2, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h48, 9'd1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h48, 9'd1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h48, 9'd1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h48, 9'd1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h48, 9'd1, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h49, 9'd0, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h49, 9'd0, 1'b1, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h49, 9'd0, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h49, 9'd0, 1'b0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      wr_req = vq[i].wr_req; wr_data = vq[i].wr_data;
      play = vq[i].play; man_done = vq[i].tx_done;
      @(negedge sysclk);
      chk($sformatf("v%0d_wr_ack", i),   32'(wr_ack),   32'(vq[i].wr_ack));
      chk($sformatf("v%0d_tx_start", i), 32'(tx_start), 32'(vq[i].tx_start));
      chk($sformatf("v%0d_tx_data", i),  32'(tx_data),  32'(vq[i].tx_data));
      chk($sformatf("v%0d_count", i),    32'(count),    32'(vq[i].count));
      chk($sformatf("v%0d_playing", i),  32'(playing),  32'(vq[i].playing));
      chk($sformatf("v%0d_err", i),      32'(err),      32'(vq[i].err));
    end
    wr_req = 1'b0; play = 1'b0; man_done = 1'b0;
    chk("ram0", 32'(mem[0]), 32'h8048);
    chk("ram1", 32'(mem[1]), 32'h8049);

    // write serviced during TX_WAIT, then write/read contention alternates
    pulse_wr(8'h41); cyc(3);
    pulse_wr(8'h42); cyc(3);
    chk("arb_count", 32'(count), 32'd2);
    base = ev_n;
    pulse_play();
    wait_for(0, 10, "arb_first_tx");
    pulse_wr(8'h43);
    wait_for(1, 5, "arb_ack_in_txwait");
    cyc(1);
    man_done = 1'b1; wr_req = 1'b1; wr_data = 8'h44; auto_tx = 1'b1;
    @(negedge sysclk);
    man_done = 1'b0; wr_req = 1'b0;
    wait_for(2, 200, "arb_drain");
    exp_ev[0] = "R"; exp_ev[1] = "W"; exp_ev[2] = "R";
    exp_ev[3] = "W"; exp_ev[4] = "R"; exp_ev[5] = "R";
    chk("arb_events", 32'(ev_n - base), 32'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("arb_ev%0d", i), 32'(ev_log[base + i]), 32'(exp_ev[i]));
    chk("arb_last_tx", 32'(tx_data), 32'h44);
    chk("arb_end_count", 32'(count), 32'd0);
    chk("arb_err", 32'(err), 32'd0);

    // back-to-back wr_req: second byte dropped
    a0 = n_ack;
    wr_req = 1'b1; wr_data = 8'h31;
    @(negedge sysclk);
    wr_data = 8'h32;
    @(negedge sysclk);
    wr_req = 1'b0;
    cyc(4);
    chk("b2b_acks", 32'(n_ack - a0), 32'd1);
    chk("b2b_count", 32'(count), 32'd1);
    chk("b2b_err", 32'(err), 32'd1);
    pulse_play();
    wait_for(2, 100, "b2b_drain");
    chk("b2b_tx_data", 32'(tx_data), 32'h31);
    chk("b2b_end_count", 32'(count), 32'd0);

    do_reset();
    chk_idle_outputs("reset2");

    // fill the buffer, then one more write
    auto_tx = 1'b0;
    for (int i = 0; i < 256; i++) begin
      pulse_wr(8'(i));
      cyc(2);
    end
    chk("fill_count", 32'(count), 32'd256);
    chk("fill_err", 32'(err), 32'd0);
    a0 = n_ack;
    pulse_wr(8'h5A);
    cyc(4);
    chk("full_count", 32'(count), 32'd256);
`ifdef WORDRAM_OVERWRITE_EN
    chk("full_acks", 32'(n_ack - a0), 32'd1);
    chk("full_err", 32'(err), 32'd0);
    chk("full_ram0", 32'(mem[0]), 32'h805A);
`else
    chk("full_acks", 32'(n_ack - a0), 32'd0);
    chk("full_err", 32'(err), 32'd1);
    chk("full_ram0", 32'(mem[0]), 32'h8000);
`endif
    pulse_play();
    wait_for(0, 10, "full_first_tx");
`ifdef WORDRAM_OVERWRITE_EN
    chk("full_first_char", 32'(tx_data), 32'h01);
`else
    chk("full_first_char", 32'(tx_data), 32'h00);
`endif
    do_reset();

    // reset during TX_WAIT
    pulse_wr(8'h52); cyc(3);
    pulse_play();
    wait_for(0, 10, "rst_tx");
    cyc(2);
    t0 = n_tx;
    reset = 1'b1;
    #1;
    chk("rst_async_playing", 32'(playing), 32'd0);
    chk("rst_async_count", 32'(count), 32'd0);
    @(negedge sysclk);
    cyc(1);
    reset = 1'b0;
    man_done = 1'b1;
    @(negedge sysclk);
    man_done = 1'b0;
    cyc(20);
    chk("rst_no_tx", 32'(n_tx - t0), 32'd0);
    chk_idle_outputs("rst_mid");

    // corrupt word at the read pointer
    pulse_wr(8'h52); cyc(3);
    pre_en = 1'b1; pre_addr = 8'h00; pre_val = 16'h0041;
    @(negedge sysclk);
    pre_en = 1'b0;
    t0 = n_tx;
    pulse_play();
    cyc(10);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_playing", 32'(playing), 32'd0);
    chk("bad_no_tx", 32'(n_tx - t0), 32'd0);
    chk("bad_count", 32'(count), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
